// File: rtl/tpu_uart_pkg.sv
// Shared definitions for the TPU UART transmit and receive paths.
package tpu_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; rdata is valid whenever empty is low.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    // Writes are blocked during reset so a held producer byte is not captured.
    assign do_push = push && !full && !rst;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first shifter with back-to-back frames.
//  state | meaning
//  IDLE  | line high, waiting for a queued byte
//  START | start bit (0) for one bit period
//  DATA  | data bits LSB-first, bit_idx selects position
//  STOP  | stop bit (1); pops next byte straight into START if available
module uart_tx_fifo
    import tpu_uart_pkg::*;
#(
    parameter  int CLK_FREQ   = 100_000_000,
    parameter  int BAUD       = 115200,
    parameter  int FIFO_DEPTH = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          uart_tx,
    output logic          tx_busy,
    output logic [CW-1:0] fifo_count
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BW  = (CPB < 2) ? 1 : $clog2(CPB);
    localparam int IW  = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

    if (CPB < 2) begin : g_cpb_check
        $error("CLKS_PER_BIT must be at least 2");
    end

    uart_tx_state_t            state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [IW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                      tx_q, tx_d;
    logic                      bit_end;
    logic                      fifo_pop;
    logic [7:0]                fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    // tx_d always carries the level of the bit being entered so the line is flop-driven.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shreg_d   = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
                        tx_d      = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

    assign uart_tx  = tx_q;
    assign tx_ready = !fifo_full;
    assign tx_busy  = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter that drives the board-level `uart_tx` pin for TPU responses and debug readback. It is the transmit-side counterpart of the TPU's UART command receiver. Producers (command responder, status dumper) push bytes over a valid/ready handshake into an internal FIFO. A shifter serialises the bytes LSB-first at a fixed baud rate and sends consecutive bytes with no idle gap.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT` = `CLK_FREQ/BAUD`, truncated, so 868 at the defaults. `CLKS_PER_BIT` must be ≥ 2; elaboration error otherwise.
- `FIFO_DEPTH`, default 16: byte entries. Must be a power of two ≥ 2.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  producer offers `tx_data`.
- `tx_ready`  out  1  FIFO not full; a byte is accepted on an edge where `tx_valid && tx_ready`.
- `uart_tx`  out  1  serial line, idles high.
- `tx_busy`  out  1  high when the shifter is not IDLE or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte in the shifter.

## Operation
- Frame: start bit (0), data[0]..data[7], stop bit (1). Each bit is held exactly `CLKS_PER_BIT` cycles.
- Shifter states:
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop the head byte into the shift register and go to START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx`=shreg[0]; shift right at each bit boundary. After bit 7 ends, go to STOP.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- `uart_tx` is driven from a flop, never from combinational logic.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and resets to 0 on every state or bit transition.
- FIFO:
  - Push on `tx_valid && tx_ready`; pop only by the shifter, only when non-empty.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
  - When full, `tx_ready`=0 and the byte is not taken; the producer holds it, so nothing is dropped.
  - Pop from an empty FIFO never occurs.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- `tx_data` is sampled only on the accepting edge; later changes have no effect on queued bytes.
- Reset, including mid-frame:
  - Next cycle: IDLE, `uart_tx`=1, FIFO emptied, `fifo_count`=0, `tx_ready`=1, `tx_busy`=0.
  - Any partially sent frame is truncated; the far end sees a framing error, which is accepted.
  - `tx_valid` is ignored while `rst`=1.

## Timing
- Reset values: `uart_tx`=1, `tx_ready`=1, `tx_busy`=0, `fifo_count`=0.
- `tx_ready` = (`fifo_count` != `FIFO_DEPTH`), decoded from registered count with no combinational path from `tx_valid`.
- Latency from idle: byte accepted at edge N, so `fifo_count`=1 after N. Shifter pops at edge N+1, so `uart_tx` falls after edge N+1: two cycles from acceptance to the start-bit edge.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `tx_busy` rises the cycle after acceptance. It falls on the cycle IDLE is entered with the FIFO empty.
- Throughput: one byte per 10×`CLKS_PER_BIT` cycles. Producer stalls only when full.

## Structure
- Package `tpu_uart_pkg`:
  - `uart_tx_state_t` enum {IDLE, START, DATA, STOP}.
  - `UART_DATA_BITS`=8.
  - Function `clks_per_bit(clk_freq, baud)`.
  - The RX side reuses the same package.
- Sub-module `sync_fifo`: parameterised width and depth; push, pop, `count`, `full`, `empty`; synchronous active-high reset; read data valid the same cycle as `!empty` (first-word fall-through).
- The top contains the shifter FSM, baud counter, bit index, and output flop.

## Test plan
Simulate with `CLK_FREQ`=400, `BAUD`=100, so `CLKS_PER_BIT`=4; `FIFO_DEPTH`=4.
- Single byte 0xA5 pushed at idle:
  - `uart_tx` falls 2 cycles later.
  - Bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - `tx_busy` clears after 40 cycles of frame.
- Push 0x00, 0xFF, 0x3C back-to-back: three frames totalling 120 cycles, with no idle-high cycles between the stop bit and the next start bit.
- Hold `tx_valid`=1 with an incrementing byte:
  - `tx_ready` drops when `fifo_count`=4.
  - Each pop re-raises `tx_ready` for one accepted push.
  - All bytes appear on the line in order; none are lost.
- Push and pop on the same edge while `fifo_count`=2: count stays 2.
- Assert `rst` for 1 cycle mid-DATA with 3 bytes queued:
  - Next cycle `uart_tx`=1, `fifo_count`=0, `tx_busy`=0.
  - A new byte 0x5A afterwards is sent correctly.
- Vary `tx_data` after acceptance while `tx_valid`=0: the transmitted byte equals the value sampled on the accepting edge.
